dcache_responder: RTL
=====================

Name: dcache_responder

Overview:
- Memory-side responder for the CPU data port. Consumes `dcache_addr`/`re`/`we`/`din` and drives `dcache_dout` and `stall`.
- Direct-mapped, write-through, no-write-allocate cache with single-word lines.
- Misses and writes are serviced over a valid/ready request channel to backing memory, with a separate response strobe.
- Sits between the pipelined CPU core and the memory system / arbiter.

Parameters:
- LINES, 64, number of one-word cache lines (power of 2, at least 2); INDEX_BITS = log2(LINES).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous active-low reset (0 = in reset)
- dcache_addr  input  32  byte address from CPU; bits [1:0] ignored
- dcache_re  input  1  read request
- dcache_we  input  4  byte write enables; nonzero = write request
- dcache_din  input  32  write data, byte lanes per dcache_we
- dcache_dout  output  32  registered load data
- stall  output  1  high while a request is being serviced; CPU holds its pipeline
- mem_req_valid  output  1  backing-memory request valid
- mem_req_ready  input  1  backing memory accepts request
- mem_req_rw  output  1  0 = read, 1 = write
- mem_req_addr  output  32  word-aligned address ([1:0] = 0)
- mem_req_data  output  32  write data
- mem_req_mask  output  4  byte mask for writes; 4'b0000 for reads
- mem_resp_valid  input  1  one-cycle response strobe (read data or write ack)
- mem_resp_data  input  32  read data, valid with mem_resp_valid

Behaviour:
- Address split: index = addr[INDEX_BITS+1:2], tag = addr[31:INDEX_BITS+2]. Valid array is reset; tag and data arrays are not.
- Reset (asynchronous, any state):
  - state = IDLE; all valid bits cleared.
  - Outputs: dcache_dout = 0, stall = 0, mem_req_valid = 0, mem_req_rw = 0, mem_req_addr = 0, mem_req_data = 0, mem_req_mask = 0.
  - Any later mem_resp_valid belonging to a pre-reset request is ignored in IDLE.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT. stall = (state != IDLE), decoded combinationally from the state register.
- Acceptance: a request is sampled at a rising edge only in IDLE. A request is present when dcache_re = 1 or dcache_we != 0. If both are set, the write wins and dcache_dout is left unchanged. Address and data are captured into internal registers, so the CPU need not hold them.
- Read hit (valid and tag match): dcache_dout = line data at the next edge. State stays IDLE; 1-cycle latency, no stall.
- Read miss: IDLE -> RD_REQ.
  - RD_REQ: mem_req_valid = 1, rw = 0, word-aligned address.
  - RD_REQ -> RD_WAIT on the edge where mem_req_ready = 1.
  - RD_WAIT: on mem_resp_valid, fill the line (data, tag, valid = 1), set dcache_dout = mem_resp_data, go to IDLE.
  - Minimum stall: 2 cycles.
- Write (hit or miss): IDLE -> WR_REQ.
  - On a hit, the line's bytes are merged per dcache_we at the acceptance edge. A miss does not allocate.
  - WR_REQ: mem_req_valid = 1, rw = 1, with data and mask.
  - WR_REQ -> WR_WAIT on ready. WR_WAIT -> IDLE on mem_resp_valid (write ack).
- Request channel: mem_req_* outputs are stable while mem_req_valid = 1 and mem_req_ready = 0. mem_req_valid deasserts in the cycle after the handshake.
- mem_resp_valid in IDLE or a *_REQ state is ignored.
- dcache_dout holds its value until the next read completes.

Optional Feature:
- Macro: DCACHE_WRITE_BUFFER_EN.
- When defined: a single-entry posted write buffer (addr, data, mask, full flag).
  - A write accepted while the buffer is empty loads the buffer and stays in IDLE, so stall = 0.
  - The buffer drains through WR_REQ/WR_WAIT-equivalent sequencing in parallel with IDLE hits.
  - A write arriving while the buffer is full, or a read miss while it is full, stalls until the buffer drains. The read miss is then issued, which preserves memory ordering.
  - Read hits never wait on the buffer.
  - Reset clears the buffer's full flag.
- When undefined: every write stalls as described in Behaviour.

Test Plan:
- Reset, then read 0x00001004 → miss. stall = 1 until a response of 0xDEADBEEF. mem_req_addr = 0x00001004, rw = 0. dcache_dout = 0xDEADBEEF, after which stall = 0.
- Reread 0x00001004 → no mem_req_valid; dcache_dout = 0xDEADBEEF on the next edge; stall stays 0.
- Write 0x000000AA with we = 4'b0001 to 0x00001004 → write request with mask 0001. After the ack, a read returns 0xDEADBEAA with no miss.
- Read 0x00001104 (same index, different tag) → miss and refill. A following read of 0x00001004 misses again.
- Hold mem_req_ready = 0 for 5 cycles during a read miss → mem_req_* stable and stall = 1 throughout. Drop reset mid-RD_WAIT → stall = 0, and a read of 0x00001004 misses.
- With DCACHE_WRITE_BUFFER_EN: two back-to-back writes → first has stall = 0, second stalls until the first is acked. Read miss after a write → read request issued only after the write ack.

Source files
------------

// File: rtl/dcache_responder.sv
// dcache_responder: memory-side responder for the CPU data port.
//
// Direct-mapped, write-through, no-write-allocate data cache with one-word
// lines. Read misses and all writes go to backing memory over a valid/ready
// request channel. Completion comes back on a one-cycle response strobe.
//
// Optional build macro: DCACHE_WRITE_BUFFER_EN
//   When defined, a single-entry posted write buffer lets a write retire in
//   IDLE without stalling. The buffered address, data and mask live in the
//   request registers, which hold still until the write ack. A write or read
//   miss that arrives while the buffer is full stalls until it drains.
//
// Ports:
//   clk, reset          clock (rising edge), async active-low reset
//   dcache_addr/re/we/din  CPU request (byte address, read, byte enables, data)
//   dcache_dout         registered load data
//   stall               high whenever the FSM is outside IDLE
//   mem_req_*           request channel to backing memory (valid/ready)
//   mem_resp_valid/data one-cycle response strobe (read data or write ack)
module dcache_responder #(
  parameter int LINES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] dcache_addr,
  input  logic        dcache_re,
  input  logic [3:0]  dcache_we,
  input  logic [31:0] dcache_din,
  output logic [31:0] dcache_dout,
  output logic        stall,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_req_rw,
  output logic [31:0] mem_req_addr,
  output logic [31:0] mem_req_data,
  output logic [3:0]  mem_req_mask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data
);

  localparam int INDEX_BITS = $clog2(LINES);
  localparam int TAG_BITS   = 32 - INDEX_BITS - 2;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_WR_WAIT = 3'd4
  } state_e;

  state_e                state_q;
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_mem [LINES];
  logic [31:0]           data_mem [LINES];
  logic [29:0]           waddr_q;      // word address of the request in service
  logic [31:0]           dout_q;
  logic                  req_valid_q;
  logic                  req_rw_q;
  logic [31:0]           req_addr_q;
  logic [31:0]           req_data_q;
  logic [3:0]            req_mask_q;
`ifdef DCACHE_WRITE_BUFFER_EN
  logic                  wb_full_q;    // buffered write not yet acknowledged
  logic                  wb_wait_q;    // buffered write handed off, awaiting ack
  logic [31:0]           wdata_q;      // write held back while buffer is full
  logic [3:0]            wmask_q;
`endif

  logic [INDEX_BITS-1:0] idx_s;
  logic [TAG_BITS-1:0]   tag_s;
  logic [INDEX_BITS-1:0] fill_idx_s;
  logic [TAG_BITS-1:0]   fill_tag_s;
  logic [31:0]           word_addr_s;
  logic                  wr_req_s;
  logic                  rd_req_s;
  logic                  hit_s;
  logic                  unused_s;

  // Byte-lane merge of new data into an old word under a byte-enable mask.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w,
                                              input logic [31:0] new_w,
                                              input logic [3:0]  be);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) begin
      r[8*b +: 8] = be[b] ? new_w[8*b +: 8] : old_w[8*b +: 8];
    end
    return r;
  endfunction

  assign idx_s       = dcache_addr[INDEX_BITS+1:2];
  assign tag_s       = dcache_addr[31:INDEX_BITS+2];
  assign fill_idx_s  = waddr_q[INDEX_BITS-1:0];
  assign fill_tag_s  = waddr_q[29:INDEX_BITS];
  assign word_addr_s = {dcache_addr[31:2], 2'b00};
  assign wr_req_s    = (dcache_we != 4'b0000);
  assign rd_req_s    = dcache_re;
  assign hit_s       = valid_q[idx_s] && (tag_mem[idx_s] == tag_s);
  assign unused_s    = ^dcache_addr[1:0];

  assign stall         = (state_q != S_IDLE);
  assign dcache_dout   = dout_q;
  assign mem_req_valid = req_valid_q;
  assign mem_req_rw    = req_rw_q;
  assign mem_req_addr  = req_addr_q;
  assign mem_req_data  = req_data_q;
  assign mem_req_mask  = req_mask_q;

  // Line storage (not reset): byte merge on a write hit at acceptance, refill on read response.
  always_ff @(posedge clk) begin
    if ((state_q == S_IDLE) && wr_req_s && hit_s) begin
      data_mem[idx_s] <= merge_bytes(data_mem[idx_s], dcache_din, dcache_we);
    end else if ((state_q == S_RD_WAIT) && mem_resp_valid) begin
      data_mem[fill_idx_s] <= mem_resp_data;
      tag_mem[fill_idx_s]  <= fill_tag_s;
    end
  end

  // Control FSM, valid bits, load data and request-channel registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      waddr_q     <= 30'd0;
      dout_q      <= 32'd0;
      req_valid_q <= 1'b0;
      req_rw_q    <= 1'b0;
      req_addr_q  <= 32'd0;
      req_data_q  <= 32'd0;
      req_mask_q  <= 4'b0000;
`ifdef DCACHE_WRITE_BUFFER_EN
      wb_full_q   <= 1'b0;
      wb_wait_q   <= 1'b0;
      wdata_q     <= 32'd0;
      wmask_q     <= 4'b0000;
`endif
    end else begin
`ifdef DCACHE_WRITE_BUFFER_EN
      // Buffer drain runs independently of the CPU-facing state. While the
      // buffer is full, no read is in flight, so it owns the channel.
      if (wb_full_q) begin
        if (!wb_wait_q) begin
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            wb_wait_q   <= 1'b1;
          end
        end else if (mem_resp_valid) begin
          wb_full_q <= 1'b0;
          wb_wait_q <= 1'b0;
        end
      end
`endif
      case (state_q)
        S_IDLE: begin
          if (wr_req_s) begin
`ifdef DCACHE_WRITE_BUFFER_EN
            if (!wb_full_q) begin
              wb_full_q   <= 1'b1;
              wb_wait_q   <= 1'b0;
              req_valid_q <= 1'b1;
              req_rw_q    <= 1'b1;
              req_addr_q  <= word_addr_s;
              req_data_q  <= dcache_din;
              req_mask_q  <= dcache_we;
            end else begin
              waddr_q <= dcache_addr[31:2];
              wdata_q <= dcache_din;
              wmask_q <= dcache_we;
              state_q <= S_WR_REQ;
            end
`else
            req_valid_q <= 1'b1;
            req_rw_q    <= 1'b1;
            req_addr_q  <= word_addr_s;
            req_data_q  <= dcache_din;
            req_mask_q  <= dcache_we;
            state_q     <= S_WR_REQ;
`endif
          end else if (rd_req_s) begin
            if (hit_s) begin
              dout_q <= data_mem[idx_s];
            end else begin
              waddr_q <= dcache_addr[31:2];
              state_q <= S_RD_REQ;
`ifdef DCACHE_WRITE_BUFFER_EN
              // A full buffer must reach memory before this read does.
              if (!wb_full_q) begin
                req_valid_q <= 1'b1;
                req_rw_q    <= 1'b0;
                req_addr_q  <= word_addr_s;
                req_data_q  <= 32'd0;
                req_mask_q  <= 4'b0000;
              end
`else
              req_valid_q <= 1'b1;
              req_rw_q    <= 1'b0;
              req_addr_q  <= word_addr_s;
              req_data_q  <= 32'd0;
              req_mask_q  <= 4'b0000;
`endif
            end
          end
        end
        S_RD_REQ: begin
`ifdef DCACHE_WRITE_BUFFER_EN
          if (wb_full_q) begin
            // Issue the read in the same edge the buffered write is acked.
            if (wb_wait_q && mem_resp_valid) begin
              req_valid_q <= 1'b1;
              req_rw_q    <= 1'b0;
              req_addr_q  <= {waddr_q, 2'b00};
              req_data_q  <= 32'd0;
              req_mask_q  <= 4'b0000;
            end
          end else if (!req_valid_q) begin
            req_valid_q <= 1'b1;
            req_rw_q    <= 1'b0;
            req_addr_q  <= {waddr_q, 2'b00};
            req_data_q  <= 32'd0;
            req_mask_q  <= 4'b0000;
          end else if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_RD_WAIT;
          end
`else
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_RD_WAIT;
          end
`endif
        end
        S_RD_WAIT: begin
          if (mem_resp_valid) begin
            valid_q[fill_idx_s] <= 1'b1;
            dout_q              <= mem_resp_data;
            state_q             <= S_IDLE;
          end
        end
        S_WR_REQ: begin
`ifdef DCACHE_WRITE_BUFFER_EN
          // Held write moves into the buffer as soon as the slot frees up.
          if (!wb_full_q || (wb_wait_q && mem_resp_valid)) begin
            wb_full_q   <= 1'b1;
            wb_wait_q   <= 1'b0;
            req_valid_q <= 1'b1;
            req_rw_q    <= 1'b1;
            req_addr_q  <= {waddr_q, 2'b00};
            req_data_q  <= wdata_q;
            req_mask_q  <= wmask_q;
            state_q     <= S_IDLE;
          end
`else
          if (mem_req_ready) begin
            req_valid_q <= 1'b0;
            state_q     <= S_WR_WAIT;
          end
`endif
        end
        S_WR_WAIT: begin
`ifdef DCACHE_WRITE_BUFFER_EN
          state_q <= S_IDLE;
`else
          if (mem_resp_valid) begin
            state_q <= S_IDLE;
          end
`endif
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
